// File: rtl/ebpf_div_pkg.sv
// ebpf_div_pkg
//   Shared definitions for the eBPF BPF_DIV/BPF_MOD issue sequencer:
//   datapath widths, the sequencer state encoding and the captured
//   operation kind.
//   Optional feature macro used by the files importing this package:
//   EBPF_SDIV_EN (signed SDIV/SMOD support).
package ebpf_div_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int HALF_WIDTH = DATA_WIDTH / 2;

  // Sequencer states. The encoding is visible on the top's dbg_state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Operation kind captured on acceptance. Signedness is not stored here:
  // once operands are converted to magnitudes only the result sign flags
  // are still needed.
  typedef struct packed {
    logic is_mod;  // 1 = remainder, 0 = quotient
    logic alu64;   // 1 = 64-bit op, 0 = 32-bit op
  } op_kind_t;

endpackage

// File: rtl/ebpf_div_signfix.sv
// ebpf_div_signfix
//   Combinational sign handling around an unsigned divider, built only
//   when EBPF_SDIV_EN is defined.
//   Pre-issue : converts sign-extended operands to magnitudes and reports
//               which operands were negative.
//   Post-ack  : negates quotient/remainder according to registered flags.
// Ports
//   en             in  1  signed operation requested
//   op_a, op_b     in  W  conditioned dividend / divisor
//   mag_a, mag_b   out W  magnitudes handed to the divider
//   a_neg, b_neg   out 1  operand was negative (gated by en)
//   neg_q, neg_r   in  1  registered: negate quotient / remainder
//   quotient       in  W  raw divider quotient
//   remainder      in  W  raw divider remainder
//   quotient_fix   out W  signed-corrected quotient
//   remainder_fix  out W  signed-corrected remainder
`ifdef EBPF_SDIV_EN
module ebpf_div_signfix #(
  parameter int W = 64
) (
  input  logic         en,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic [W-1:0] mag_a,
  output logic [W-1:0] mag_b,
  output logic         a_neg,
  output logic         b_neg,
  input  logic         neg_q,
  input  logic         neg_r,
  input  logic [W-1:0] quotient,
  input  logic [W-1:0] remainder,
  output logic [W-1:0] quotient_fix,
  output logic [W-1:0] remainder_fix
);

  assign a_neg = en & op_a[W-1];
  assign b_neg = en & op_b[W-1];

  // The magnitude of INT_MIN is itself; read as unsigned it is exactly
  // 2^(W-1), so INT_MIN/-1 and INT_MIN%-1 come out right without a
  // special case.
  assign mag_a = a_neg ? -op_a : op_a;
  assign mag_b = b_neg ? -op_b : op_b;

  assign quotient_fix  = neg_q ? -quotient  : quotient;
  assign remainder_fix = neg_r ? -remainder : remainder;

endmodule
`endif

// File: rtl/ebpf_div_sequencer.sv
// ebpf_div_sequencer
//   Issue stage in front of a sequential divider for eBPF BPF_DIV/BPF_MOD
//   (ALU and ALU64). Accepts one instruction, conditions operands, strobes
//   the divider, waits for its ack, selects quotient or remainder and
//   applies the eBPF result rules (32-bit zero extension, divide by zero).
//   Optional feature: define EBPF_SDIV_EN for signed SDIV/SMOD
//   (req_signed honoured). Without it req_signed is ignored.
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   req_valid/ready instruction handshake; req_mod, req_alu64, req_signed,
//                   req_dst (dividend), req_src (divisor)
//   res_valid/ready result handshake; res_data, res_divzero
//   div_dividend, div_divisor, div_stb   to the divider
//   div_quotient, div_remainder, div_ack, div_err   from the divider
//   dbg_state       current sequencer state (ebpf_div_pkg::state_t)
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// req_ready depends only on state (high in IDLE). res_valid is high in OUT
// and res_data/res_divzero hold steady until the edge where res_ready is
// seen; the sequencer then returns to IDLE and only accepts a new request
// on a later edge.
module ebpf_div_sequencer
  import ebpf_div_pkg::*;
#(
  parameter int DATA_WIDTH = ebpf_div_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mod,
  input  logic                  req_alu64,
  input  logic                  req_signed,
  input  logic [DATA_WIDTH-1:0] req_dst,
  input  logic [DATA_WIDTH-1:0] req_src,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_divzero,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  output logic                  div_stb,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder,
  input  logic                  div_ack,
  input  logic                  div_err,
  output logic [1:0]            dbg_state
);

  localparam int HALF = DATA_WIDTH / 2;

  state_t                state, state_next;
  op_kind_t              op;
  logic [DATA_WIDTH-1:0] dst_r;
  logic [DATA_WIDTH-1:0] cond_dst, cond_src;
  logic [DATA_WIDTH-1:0] iss_dividend, iss_divisor;
  logic [DATA_WIDTH-1:0] quo_fix, rem_fix, div_result;
  logic                  dst_fill, src_fill;
  logic                  src_zero;
  logic                  accept;

  // eBPF divide-by-zero result: DIV gives 0, MOD leaves dst unchanged
  // (truncated to 32 bits and zero-extended for ALU32).
  function automatic logic [DATA_WIDTH-1:0] zero_rule(
    input logic                  is_mod,
    input logic                  alu64,
    input logic [DATA_WIDTH-1:0] dst
  );
    if (!is_mod) return '0;
    if (alu64)   return dst;
    return {{HALF{1'b0}}, dst[HALF-1:0]};
  endfunction

  assign accept = (state == ST_IDLE) && req_valid;

  // ---------------------------------------------------------------------
  // Operand conditioning: 32-bit ops use the low half, zero-extended for
  // unsigned and sign-extended for signed ops.
  // ---------------------------------------------------------------------
`ifdef EBPF_SDIV_EN
  assign dst_fill = req_signed & req_dst[HALF-1];
  assign src_fill = req_signed & req_src[HALF-1];
`else
  logic unused_signed;
  assign dst_fill      = 1'b0;
  assign src_fill      = 1'b0;
  assign unused_signed = req_signed;
`endif

  always_comb begin
    cond_dst = req_dst;
    cond_src = req_src;
    if (!req_alu64) begin
      cond_dst = {{HALF{dst_fill}}, req_dst[HALF-1:0]};
      cond_src = {{HALF{src_fill}}, req_src[HALF-1:0]};
    end
  end

  // Sign extension never changes zero-ness, so this also covers signed ops.
  assign src_zero = (cond_src == '0);

`ifdef EBPF_SDIV_EN
  logic a_neg, b_neg, neg_q, neg_r;

  ebpf_div_signfix #(
    .W (DATA_WIDTH)
  ) u_signfix (
    .en            (req_signed),
    .op_a          (cond_dst),
    .op_b          (cond_src),
    .mag_a         (iss_dividend),
    .mag_b         (iss_divisor),
    .a_neg         (a_neg),
    .b_neg         (b_neg),
    .neg_q         (neg_q),
    .neg_r         (neg_r),
    .quotient      (div_quotient),
    .remainder     (div_remainder),
    .quotient_fix  (quo_fix),
    .remainder_fix (rem_fix)
  );

  // Quotient is negative when operand signs differ; remainder follows the
  // dividend.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  assign iss_dividend = cond_dst;
  assign iss_divisor  = cond_src;
  assign quo_fix      = div_quotient;
  assign rem_fix      = div_remainder;
`endif

  always_comb begin
    div_result = op.is_mod ? rem_fix : quo_fix;
    if (!op.alu64) div_result[DATA_WIDTH-1:HALF] = '0;
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    res_valid  = 1'b0;
    div_stb    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = src_zero ? ST_OUT : ST_ISSUE;
      end
      ST_ISSUE: begin
        // div_ack is stale here; the divider only reacts to this strobe.
        div_stb    = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_ack) state_next = ST_OUT;
      end
      ST_OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op           <= '0;
      dst_r        <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      res_data     <= '0;
      res_divzero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op.is_mod    <= req_mod;
            op.alu64     <= req_alu64;
            dst_r        <= req_dst;
            div_dividend <= iss_dividend;
            div_divisor  <= iss_divisor;
            res_divzero  <= src_zero;
            if (src_zero) res_data <= zero_rule(req_mod, req_alu64, req_dst);
          end
        end
        ST_WAIT: begin
          if (div_ack) begin
            // div_err should be unreachable since zero divisors never get
            // here; fall back to the same rule rather than trust the data.
            if (div_err) begin
              res_data    <= zero_rule(op.is_mod, op.alu64, dst_r);
              res_divzero <= 1'b1;
            end else begin
              res_data    <= div_result;
              res_divzero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ebpf_div_sequencer.sv
// tb_ebpf_div_sequencer
//   Bench for ebpf_div_sequencer. Contains a behavioural 64-bit divider
//   (strobe sampled on edge S, ack and results presented after edge S+63),
//   a driver that pushes the reference-model result for every accepted
//   request, and a monitor that owns res_ready and pops/compares each
//   delivered result. Latency is counted as the number of rising edges from
//   the accepting edge to the first edge that samples res_valid high:
//   1 for a zero divisor, 66 through the divider.
//   Build with +define+EBPF_SDIV_EN to add the signed cases.
module tb_ebpf_div_sequencer;

  localparam int W        = 64;
  localparam int EXP_W    = 66;  // {stb_expected, divzero, data}
  localparam int LAT_DIV  = 66;
  localparam int LAT_ZERO = 1;
  localparam int N_RAND   = 200;

  logic         clk;
  logic         reset;
  logic         req_valid, req_ready, req_mod, req_alu64, req_signed;
  logic [W-1:0] req_dst, req_src;
  logic         res_valid, res_ready, res_divzero;
  logic [W-1:0] res_data;
  logic [W-1:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic         div_stb, div_ack, div_err;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_cycles = -1;  // >= 0 forces the res_ready stall length
  bit stuck = 0;

  logic [EXP_W-1:0] exp_q[$];
  int               acc_q[$];

  ebpf_div_sequencer #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_mod       (req_mod),
    .req_alu64     (req_alu64),
    .req_signed    (req_signed),
    .req_dst       (req_dst),
    .req_src       (req_src),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_divzero   (res_divzero),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_stb       (div_stb),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_ack       (div_ack),
    .div_err       (div_err),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- divider model ----------------
  int         dv_cnt;
  logic [W-1:0] dv_a, dv_b;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      div_ack       <= 1'b1;
      div_err       <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
      dv_cnt        <= 0;
      dv_a          <= '0;
      dv_b          <= '0;
    end else if (div_stb) begin
      div_ack <= 1'b0;
      dv_cnt  <= 63;
      dv_a    <= div_dividend;
      dv_b    <= div_divisor;
    end else if (!div_ack) begin
      if (dv_cnt == 1) begin
        div_ack       <= 1'b1;
        div_err       <= (dv_b == '0);
        div_quotient  <= (dv_b == '0) ? '1   : dv_a / dv_b;
        div_remainder <= (dv_b == '0) ? dv_a : dv_a % dv_b;
      end
      dv_cnt <= dv_cnt - 1;
    end
  end

  // ---------------- reference model ----------------
`ifdef EBPF_SDIV_EN
  function automatic logic [W-1:0] signed_ref(input logic m, input logic a64,
                                              input logic [W-1:0] d, input logic [W-1:0] s);
    longint sa, sb;
    int     ha, hb;
    if (a64) begin
      if (d == 64'h8000_0000_0000_0000 && s == 64'hFFFF_FFFF_FFFF_FFFF)
        return m ? 64'd0 : d;
      sa = d;
      sb = s;
      return m ? 64'(sa % sb) : 64'(sa / sb);
    end
    if (d[31:0] == 32'h8000_0000 && s[31:0] == 32'hFFFF_FFFF)
      return m ? 64'd0 : 64'h0000_0000_8000_0000;
    ha = d[31:0];
    hb = s[31:0];
    return m ? {32'd0, 32'(ha % hb)} : {32'd0, 32'(ha / hb)};
  endfunction
`endif

  // Returns {divzero, data}.
  function automatic logic [W:0] ref_model(input logic m, input logic a64, input logic sg,
                                           input logic [W-1:0] d, input logic [W-1:0] s);
    logic [W-1:0] a, b, res;
`ifndef EBPF_SDIV_EN
    logic unused_sg;
    unused_sg = sg;
`endif
    a = a64 ? d : {32'd0, d[31:0]};
    b = a64 ? s : {32'd0, s[31:0]};
    if (b == '0) return m ? {1'b1, a} : {1'b1, 64'd0};
    res = m ? a % b : a / b;
`ifdef EBPF_SDIV_EN
    if (sg) res = signed_ref(m, a64, d, s);
`endif
    if (!a64) res[63:32] = 32'd0;
    return {1'b0, res};
  endfunction

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic m, input logic a64, input logic sg,
                      input logic [W-1:0] d, input logic [W-1:0] s);
    logic [W:0] r;
    int guard;
    if (stuck) return;
    r = ref_model(m, a64, sg, d, s);
    req_valid  = 1'b1;
    req_mod    = m;
    req_alu64  = a64;
    req_signed = sg;
    req_dst    = d;
    req_src    = s;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      checks++;
      errors++;
      stuck = 1;
      $display("FAIL accept_timeout: req_ready low for %0d cycles, expected 1", guard);
    end else begin
      exp_q.push_back({~r[W], r});
      acc_q.push_back(cyc + 1);  // accepted on the coming rising edge
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      checks++;
      errors++;
      stuck = 1;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic             prev_valid, prev_stb;
  int               stb_cnt, stall_left, rise_cyc, mon_acc;
  logic [EXP_W-1:0] mon_e;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_stb   = 1'b0;
      stb_cnt    = 0;
      stall_left = 0;
      res_ready  = 1'b0;
    end else begin
      if (div_stb) begin
        chk("stb_single_cycle", {63'd0, prev_stb}, 64'd0);
        stb_cnt++;
      end
      prev_stb = div_stb;
      if (res_valid) begin
        chk("req_ready_low_in_out", {63'd0, req_ready}, 64'd0);
        if (!prev_valid) begin
          rise_cyc   = cyc;
          stall_left = (hold_cycles >= 0) ? hold_cycles : $urandom_range(0, 3);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: data 0x%h with no request outstanding", res_data);
          res_ready = 1'b1;
        end else if (stall_left > 0) begin
          res_ready = 1'b0;
          stall_left--;
          mon_e = exp_q[0];
          chk("held_res_data", res_data, mon_e[63:0]);
          chk("held_res_divzero", {63'd0, res_divzero}, {63'd0, mon_e[64]});
        end else begin
          res_ready = 1'b1;
          mon_e   = exp_q.pop_front();
          mon_acc = acc_q.pop_front();
          chk("res_data", res_data, mon_e[63:0]);
          chk("res_divzero", {63'd0, res_divzero}, {63'd0, mon_e[64]});
          chk("latency", 64'(rise_cyc + 1 - mon_acc), mon_e[64] ? 64'(LAT_ZERO) : 64'(LAT_DIV));
          chk("stb_count", 64'(stb_cnt), {63'd0, mon_e[65]});
          stb_cnt = 0;
        end
      end else begin
        res_ready = 1'($urandom_range(0, 1));
      end
      prev_valid = res_valid;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(10 * 80000);
    checks++;
    errors++;
    $display("FAIL watchdog: simulation exceeded 80000 cycles");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] rd, rs;
  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_mod    = 1'b0;
    req_alu64  = 1'b0;
    req_signed = 1'b0;
    req_dst    = '0;
    req_src    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset values
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_res_divzero", {63'd0, res_divzero}, 64'd0);
    chk("rst_div_stb", {63'd0, div_stb}, 64'd0);
    chk("rst_div_dividend", div_dividend, 64'd0);
    chk("rst_div_divisor", div_divisor, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);

    // directed cases
    send(1'b0, 1'b1, 1'b0, 64'd100, 64'd7);                          // 14
    send(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_000A, 64'd3);          // 1
    send(1'b1, 1'b1, 1'b0, 64'h1234, 64'd0);                         // 0x1234, divzero
    send(1'b0, 1'b1, 1'b0, 64'h1234, 64'd0);                         // 0, divzero
    send(1'b0, 1'b0, 1'b0, 64'hDEAD_BEEF, 64'h1_0000_0000);          // low half zero
    send(1'b1, 1'b0, 1'b0, 64'hABCD_0000_1234_5678, 64'h7_0000_0000); // 32-bit MOD by 0
    drain();

    // result held 10 cycles while a new request waits
    hold_cycles = 10;
    send(1'b0, 1'b1, 1'b0, 64'd1_000_000, 64'd13);
    send(1'b1, 1'b1, 1'b0, 64'h55, 64'd0);
    drain();
    hold_cycles = -1;

    // reset in the middle of WAIT
    send(1'b0, 1'b1, 1'b0, 64'd1000, 64'd3);
    repeat (10) @(negedge clk);
    chk("mid_wait_state", {62'd0, dbg_state}, 64'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("mid_rst_state", {62'd0, dbg_state}, 64'd0);
    chk("mid_rst_div_dividend", div_dividend, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("post_rst_res_valid", {63'd0, res_valid}, 64'd0);
    send(1'b0, 1'b1, 1'b0, 64'd81, 64'd9);
    drain();

`ifdef EBPF_SDIV_EN
    send(1'b0, 1'b1, 1'b1, -64'sd7, 64'd2);                          // -3
    send(1'b1, 1'b1, 1'b1, -64'sd7, 64'd2);                          // -1
    send(1'b0, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2);          // 32-bit -3
    send(1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    send(1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    send(1'b0, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
    send(1'b1, 1'b1, 1'b1, -64'sd9, 64'd0);                          // zero rule
    drain();
`endif

    // randomized traffic
    for (int i = 0; i < N_RAND; i++) begin
      if (stuck) break;
      case ($urandom_range(0, 5))
        0:       rs = 64'd0;
        1:       rs = {$urandom, 32'd0};
        2:       rs = 64'($urandom_range(1, 15));
        3:       rs = 64'hFFFF_FFFF_FFFF_FFFF;
        default: rs = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 4))
        0:       rd = 64'h8000_0000_0000_0000;
        1:       rd = {$urandom, 32'h8000_0000};
        2:       rd = 64'($urandom_range(0, 1000));
        default: rd = {$urandom, $urandom};
      endcase
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, rs);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
